modulo_controle_ataque: RTL and testbench
=========================================

// Module: modulo_controle_ataque
// PURPOSE
//  Upstream game-control stage for the matrix/7-seg display datapath. Debounces raw
//  button_confirmation and turns each press into one confirm event. Tracks game phase
//  from the mode switches and validates the row/col coordinate. Issues one-cycle
//  store strobes for the position and attack matrices, and keeps hit/shot counters
//  plus a status code for the 7-segment mux.
// PARAMETERS
//  DEB_CYCLES  500000  clk cycles of stable input needed to accept a level (10 ms @ 50 MHz)
//  DEB_W       19      debounce counter width; must satisfy 2**DEB_W > DEB_CYCLES
//  MAX_SHOTS   20      shots granted per game, 1..31
//  SHIP_CELLS  9       occupied cells in a placement; all hit = victory
// PORTS
//  clk                  in   1  system clock
//  clr                  in   1  asynchronous reset, active-low
//  button_confirmation  in   1  raw push-button, active-low, asynchronous to clk
//  hh1                  in   2  mode: 00 idle, 01 position, 10 attack, 11 view
//  hh2                  in   6  coord: [5:3] row 0..6, [2:0] col 0..4
//  cell_occupied        in   1  ship present at hh2 (from position matrix), combinational
//  cell_attacked        in   1  hh2 already attacked (from attack matrix), combinational
//  confirm_pulse        out  1  one-cycle debounced press event
//  store_pos            out  1  one-cycle load strobe for position matrix
//  store_at             out  1  one-cycle write strobe for attack cell at hh2
//  clr_mats             out  1  one-cycle clear strobe for both matrices
//  hit_flag             out  1  last accepted shot was a hit; held until next shot/clear
//  hit_count            out  4  accepted hits
//  shots_left           out  5  remaining shots
//  status               out  4  0 idle,1 pos,2 atk,3 win,4 lose,4'hE error
//  game_over            out  1  high in FIM state
// BEHAVIOUR
//  Reset (clr=0, async): all outputs 0. shots_left=MAX_SHOTS, state IDLE, pos_valid=0, debouncer cleared.
//  Debounce: 2-FF synchronizer, then counter; a level is accepted after DEB_CYCLES
//   consecutive equal samples, and any change restarts the count. A pressed (0) acceptance
//   after released gives confirm_pulse for 1 cycle. Latency from a stable edge is
//   DEB_CYCLES+3 cycles. A held button gives exactly one pulse.
//  FSM states IDLE, POSICAO, ATAQUE, FIM. State follows hh1 every cycle (00->IDLE,
//   01->POSICAO, 10->ATAQUE, 11 keeps the current state), except FIM: it is left only via hh1=00.
//  Strobes are registered: they are asserted the cycle after confirm_pulse, and
//   cell_occupied/cell_attacked are sampled in the confirm_pulse cycle.
//  Confirm handling:
//   - IDLE: clr_mats strobe, pos_valid<=0, hit_count<=0, shots_left<=MAX_SHOTS, hit_flag<=0.
//   - POSICAO: store_pos strobe, pos_valid<=1, counters reset as in IDLE.
//   - ATAQUE, reject case: row>6, col>4, cell_attacked=1, or pos_valid=0. Sets status=E.
//     No strobe is issued and the counters are unchanged.
//   - ATAQUE, accept case: store_at strobe, shots_left-1, hit_flag<=cell_occupied,
//     hit_count+cell_occupied.
//   - FIM: ignored.
//  End of game is evaluated on the post-update values of an accepted shot.
//   hit_count==SHIP_CELLS -> FIM, status 3.
//   else shots_left==0 -> FIM, status 4. Win has priority on the final shot.
//  Counters saturate: hit_count never exceeds SHIP_CELLS and shots_left never wraps below 0.
//  status E is held until the next accepted confirm or an hh1 change. Otherwise it mirrors the state.
//  hh1 changing in the same cycle as confirm_pulse: the confirm uses the state before the change.
//  At most one strobe is high per cycle.
// STRUCTURE
//  Shared package/header: state encodings, status codes, ROW_MAX=6, COL_MAX=4.
//  Sub-module modulo_debounce (sync + counter + edge pulse, parameterised DEB_CYCLES/DEB_W).
//  Parent holds the FSM, coordinate check, counters and strobe registers.
// TESTING (bench DEB_CYCLES=4, MAX_SHOTS=3, SHIP_CELLS=2)
//  1 Bounce: toggle button every 2 clk for 10 clk, then hold low 20 clk -> exactly one confirm_pulse.
//  2 hh1=01 + press -> store_pos once. hh1=10, hh2=6'o12, occupied=1 + press -> store_at,
//    hit_count=1, shots_left=2, hit_flag=1.
//  3 Attack hh2=6'o75 (row 7) and a repeated cell_attacked=1 -> no store_at, status=E, counters unchanged.
//  4 Two hits on the 2nd and 3rd shots -> FIM, status=3, game_over=1. Further presses ignored.
//    hh1=00 -> IDLE.
//  5 Three misses -> status=4, shots_left=0. A 4th press gives no strobe and no underflow.
//  6 clr low mid-debounce and mid-game -> all outputs 0, shots_left=3, no pulse after release.

Source files
------------

// File: rtl/modulo_controle_ataque_pkg.sv
// Shared encodings for the attack-control stage: FSM states, hh1 modes,
// 7-segment status codes and the playable board limits.
package modulo_controle_ataque_pkg;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_POSICAO = 2'd1;
  localparam logic [1:0] ST_ATAQUE  = 2'd2;
  localparam logic [1:0] ST_FIM     = 2'd3;

  // Mode switch (hh1) encodings
  localparam logic [1:0] MODE_IDLE = 2'b00;
  localparam logic [1:0] MODE_POS  = 2'b01;
  localparam logic [1:0] MODE_ATK  = 2'b10;
  localparam logic [1:0] MODE_VIEW = 2'b11;

  // Status codes shown on the 7-segment mux
  localparam logic [3:0] STS_IDLE = 4'h0;
  localparam logic [3:0] STS_POS  = 4'h1;
  localparam logic [3:0] STS_ATK  = 4'h2;
  localparam logic [3:0] STS_WIN  = 4'h3;
  localparam logic [3:0] STS_LOSE = 4'h4;
  localparam logic [3:0] STS_ERR  = 4'hE;

  // Board limits: rows 0..6, cols 0..4
  localparam logic [2:0] ROW_MAX = 3'd6;
  localparam logic [2:0] COL_MAX = 3'd4;

  // hh2 packs {row[2:0], col[2:0]}; true when the coordinate lies on the board
  function automatic logic coord_in_range(input logic [5:0] coord);
    return (coord[5:3] <= ROW_MAX) && (coord[2:0] <= COL_MAX);
  endfunction

endpackage

// File: rtl/modulo_debounce.sv
// Push-button debouncer: 2-FF synchronizer, stability counter and a one-cycle
// pulse on each accepted press (released -> pressed). Button is active-low.
module modulo_debounce #(
  parameter int DEB_CYCLES = 500000,
  parameter int DEB_W      = 19
) (
  input  logic clk,
  input  logic clr,
  input  logic i_btn_n,
  output logic o_pulse
);

  localparam logic [DEB_W-1:0] CNT_LAST = DEB_W'(DEB_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic             r_stable_d;
  logic             r_pulse;
  logic [DEB_W-1:0] r_cnt;

  // Bring the asynchronous button into the clk domain.
  // The debouncer clears to "pressed" so a button held through reset never
  // produces a press; a release must be accepted first.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      // NOTE: non-blocking so both flops sample the pre-edge values and form a real two-stage chain.
      r_sync1 <= i_btn_n;
      r_sync2 <= r_sync1;
    end
  end

  // Count consecutive samples that differ from the accepted level; a sample
  // equal to the accepted level restarts the count.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_cnt    <= '0;
      r_stable <= 1'b0;
    end else if (r_sync2 == r_stable) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt    <= '0;
      r_stable <= r_sync2;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // One-cycle pulse on an accepted falling level (press).
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_stable_d <= 1'b0;
      r_pulse    <= 1'b0;
    end else begin
      r_stable_d <= r_stable;
      r_pulse    <= r_stable_d & ~r_stable;
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/modulo_controle_ataque.sv
// Game-control stage: debounced confirm, phase FSM driven by hh1, coordinate
// validation, registered matrix strobes, hit/shot counters and status code.
module modulo_controle_ataque
  import modulo_controle_ataque_pkg::*;
#(
  parameter int DEB_CYCLES = 500000,
  parameter int DEB_W      = 19,
  parameter int MAX_SHOTS  = 20,
  parameter int SHIP_CELLS = 9
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       button_confirmation,
  input  logic [1:0] hh1,
  input  logic [5:0] hh2,
  input  logic       cell_occupied,
  input  logic       cell_attacked,
  output logic       confirm_pulse,
  output logic       store_pos,
  output logic       store_at,
  output logic       clr_mats,
  output logic       hit_flag,
  output logic [3:0] hit_count,
  output logic [4:0] shots_left,
  output logic [3:0] status,
  output logic       game_over
);

  localparam logic [4:0] SHOTS_INIT = 5'(MAX_SHOTS);
  localparam logic [3:0] HITS_WIN   = 4'(SHIP_CELLS);

  logic       w_confirm;
  logic       w_idle_cfm;
  logic       w_pos_cfm;
  logic       w_atk_cfm;
  logic       w_shot_bad;
  logic       w_shot_ok;
  logic       w_shot_rej;
  logic       w_cfm_accepted;
  logic [3:0] w_hits_next;
  logic [4:0] w_shots_next;
  logic       w_win;
  logic       w_game_end;
  logic [1:0] w_state_next;

  logic [1:0] r_state;
  logic [1:0] r_hh1_q;
  logic       r_pos_valid;
  logic [3:0] r_hit_count;
  logic [4:0] r_shots_left;
  logic       r_hit_flag;
  logic       r_won;
  logic       r_err;
  logic       r_store_pos;
  logic       r_store_at;
  logic       r_clr_mats;

  modulo_debounce #(
    .DEB_CYCLES (DEB_CYCLES),
    .DEB_W      (DEB_W)
  ) u_debounce (
    .clk     (clk),
    .clr     (clr),
    .i_btn_n (button_confirmation),
    .o_pulse (w_confirm)
  );

  // Confirm decode uses the registered state, so an hh1 change in the same
  // cycle does not affect which action the press performs.
  assign w_idle_cfm     = w_confirm && (r_state == ST_IDLE);
  assign w_pos_cfm      = w_confirm && (r_state == ST_POSICAO);
  assign w_atk_cfm      = w_confirm && (r_state == ST_ATAQUE);
  assign w_shot_bad     = !coord_in_range(hh2) || cell_attacked || !r_pos_valid;
  assign w_shot_ok      = w_atk_cfm && !w_shot_bad;
  assign w_shot_rej     = w_atk_cfm && w_shot_bad;
  assign w_cfm_accepted = w_idle_cfm || w_pos_cfm || w_shot_ok;

  // Saturating post-shot counter values; the end-of-game test looks at these.
  assign w_hits_next  = (cell_occupied && (r_hit_count < HITS_WIN)) ? r_hit_count + 4'd1
                                                                      : r_hit_count;
  assign w_shots_next = (r_shots_left == 5'd0) ? 5'd0 : r_shots_left - 5'd1;
  assign w_win        = (w_hits_next == HITS_WIN);
  assign w_game_end   = w_shot_ok && (w_win || (w_shots_next == 5'd0));

  // Next state: follow hh1 (11 holds), FIM only exits on hh1=00, a finishing shot forces FIM.
  always_comb begin
    // NOTE: default first so every path assigns w_state_next and no latch is inferred.
    w_state_next = r_state;
    if (r_state == ST_FIM) begin
      if (hh1 == MODE_IDLE) w_state_next = ST_IDLE;
    end else if (w_game_end) begin
      w_state_next = ST_FIM;
    end else begin
      case (hh1)
        MODE_IDLE: w_state_next = ST_IDLE;
        MODE_POS:  w_state_next = ST_POSICAO;
        MODE_ATK:  w_state_next = ST_ATAQUE;
        default:   w_state_next = r_state;
      endcase
    end
  end

  // State register plus the previous hh1 used to detect mode changes.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state <= ST_IDLE;
      r_hh1_q <= MODE_IDLE;
    end else begin
      r_state <= w_state_next;
      r_hh1_q <= hh1;
    end
  end

  // Placement validity, counters and last-shot hit flag.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_pos_valid  <= 1'b0;
      r_hit_count  <= 4'd0;
      r_shots_left <= SHOTS_INIT;
      r_hit_flag   <= 1'b0;
    end else if (w_idle_cfm || w_pos_cfm) begin
      r_pos_valid  <= w_pos_cfm;
      r_hit_count  <= 4'd0;
      r_shots_left <= SHOTS_INIT;
      r_hit_flag   <= 1'b0;
    end else if (w_shot_ok) begin
      r_hit_count  <= w_hits_next;
      r_shots_left <= w_shots_next;
      r_hit_flag   <= cell_occupied;
    end
  end

  // Game result latched on the finishing shot; shown while in FIM.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_won <= 1'b0;
    end else if (w_game_end) begin
      r_won <= w_win;
    end
  end

  // Error flag: set by a rejected shot, held until an accepted confirm or an hh1 change.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_err <= 1'b0;
    end else if (w_shot_rej) begin
      r_err <= 1'b1;
    end else if (w_cfm_accepted || (hh1 != r_hh1_q)) begin
      r_err <= 1'b0;
    end
  end

  // One-cycle strobes, registered from the confirm cycle; mutually exclusive by state.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_clr_mats  <= 1'b0;
      r_store_pos <= 1'b0;
      r_store_at  <= 1'b0;
    end else begin
      r_clr_mats  <= w_idle_cfm;
      r_store_pos <= w_pos_cfm;
      r_store_at  <= w_shot_ok;
    end
  end

  // Status mirrors the state unless an error is pending.
  always_comb begin
    status = STS_IDLE;
    if (r_err) begin
      status = STS_ERR;
    end else begin
      case (r_state)
        ST_POSICAO: status = STS_POS;
        ST_ATAQUE:  status = STS_ATK;
        ST_FIM:     status = r_won ? STS_WIN : STS_LOSE;
        default:    status = STS_IDLE;
      endcase
    end
  end

  assign confirm_pulse = w_confirm;
  assign store_pos     = r_store_pos;
  assign store_at      = r_store_at;
  assign clr_mats      = r_clr_mats;
  assign hit_flag      = r_hit_flag;
  assign hit_count     = r_hit_count;
  assign shots_left    = r_shots_left;
  assign game_over     = (r_state == ST_FIM);

endmodule

// File: tb/tb_modulo_controle_ataque.sv
// Self-checking bench for modulo_controle_ataque with a short debounce,
// three shots per game and two ship cells. Strobes are scored against a
// queue of expected events pushed before each press.
module tb_modulo_controle_ataque;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       button_confirmation = 1'b1;
  logic [1:0] hh1 = 2'b00;
  logic [5:0] hh2 = 6'o00;
  logic       cell_occupied = 1'b0;
  logic       cell_attacked = 1'b0;
  logic       confirm_pulse;
  logic       store_pos;
  logic       store_at;
  logic       clr_mats;
  logic       hit_flag;
  logic [3:0] hit_count;
  logic [4:0] shots_left;
  logic [3:0] status;
  logic       game_over;

  // strobe vector order: {store_at, store_pos, clr_mats}
  localparam logic [2:0] K_CLR = 3'b001;
  localparam logic [2:0] K_POS = 3'b010;
  localparam logic [2:0] K_AT  = 3'b100;

  typedef struct packed {
    logic [2:0] strobes;
    logic [3:0] hits;
    logic [4:0] shots;
    logic       flag;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   errors   = 0;
  int   n_pulses = 0;

  modulo_controle_ataque #(
    .DEB_CYCLES (4),
    .DEB_W      (3),
    .MAX_SHOTS  (3),
    .SHIP_CELLS (2)
  ) dut (
    .clk                 (clk),
    .clr                 (clr),
    .button_confirmation (button_confirmation),
    .hh1                 (hh1),
    .hh2                 (hh2),
    .cell_occupied       (cell_occupied),
    .cell_attacked       (cell_attacked),
    .confirm_pulse       (confirm_pulse),
    .store_pos           (store_pos),
    .store_at            (store_at),
    .clr_mats            (clr_mats),
    .hit_flag            (hit_flag),
    .hit_count           (hit_count),
    .shots_left          (shots_left),
    .status              (status),
    .game_over           (game_over)
  );

  always #5 clk = ~clk;

  // Scoreboard side: count pulses, compare every strobe against the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (confirm_pulse) n_pulses++;
    if (store_pos || store_at || clr_mats) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL strobe_unexpected got strobes=%b hits=%0d shots=%0d", {store_at, store_pos, clr_mats}, hit_count, shots_left);
      end else begin
        e = sb.pop_front();
        if ({store_at, store_pos, clr_mats, hit_count, shots_left, hit_flag} !== e) begin
          errors++;
          $display("FAIL strobe_event got strobes=%b hits=%0d shots=%0d flag=%b expected strobes=%b hits=%0d shots=%0d flag=%b",
                   {store_at, store_pos, clr_mats}, hit_count, shots_left, hit_flag, e.strobes, e.hits, e.shots, e.flag);
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_strobe(input logic [2:0] s, input logic [3:0] h, input logic [4:0] sh, input logic f);
    exp_t e;
    e.strobes = s; e.hits = h; e.shots = sh; e.flag = f;
    sb.push_back(e);
  endtask

  // Press, hold, release; every expected strobe must have drained by the end.
  task automatic press();
    button_confirmation = 1'b0;
    wait_cyc(14);
    button_confirmation = 1'b1;
    wait_cyc(14);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL strobe_timeout pending=%0d expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic set_mode(input logic [1:0] m);
    hh1 = m;
    wait_cyc(3);
  endtask

  task automatic test_reset();
    clr = 1'b0;
    wait_cyc(3);
    checks++;
    if ({confirm_pulse, store_pos, store_at, clr_mats, hit_flag, hit_count, shots_left, status, game_over} !==
        {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 5'd3, 4'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs got hits=%0d shots=%0d status=%h go=%b expected hits=0 shots=3 status=0 go=0", hit_count, shots_left, status, game_over);
    end
    clr = 1'b1;
    wait_cyc(20);
  endtask

  task automatic test_bounce();
    int p0;
    p0 = n_pulses;
    expect_strobe(K_CLR, 4'd0, 5'd3, 1'b0);
    for (int i = 0; i < 5; i++) begin
      button_confirmation = ~button_confirmation;
      wait_cyc(2);
    end
    wait_cyc(20);
    button_confirmation = 1'b1;
    wait_cyc(20);
    checks++;
    if (n_pulses - p0 != 1) begin
      errors++;
      $display("FAIL bounce_pulses got %0d expected 1", n_pulses - p0);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL bounce_clr_mats pending=%0d expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_position_attack();
    set_mode(2'b01);
    expect_strobe(K_POS, 4'd0, 5'd3, 1'b0);
    press();
    checks++;
    if (status !== 4'h1) begin
      errors++;
      $display("FAIL pos_status got %h expected 1", status);
    end
    set_mode(2'b10);
    hh2 = 6'o12; cell_occupied = 1'b1; cell_attacked = 1'b0;
    expect_strobe(K_AT, 4'd1, 5'd2, 1'b1);
    press();
    checks++;
    if ({status, hit_count, shots_left, hit_flag, game_over} !== {4'h2, 4'd1, 5'd2, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL first_hit got status=%h hits=%0d shots=%0d flag=%b expected status=2 hits=1 shots=2 flag=1", status, hit_count, shots_left, hit_flag);
    end
  endtask

  task automatic test_reject();
    hh2 = 6'o75; cell_occupied = 1'b1; cell_attacked = 1'b0;
    press();
    checks++;
    if ({status, hit_count, shots_left, hit_flag} !== {4'hE, 4'd1, 5'd2, 1'b1}) begin
      errors++;
      $display("FAIL reject_row got status=%h hits=%0d shots=%0d expected status=e hits=1 shots=2", status, hit_count, shots_left);
    end
    hh2 = 6'o12; cell_attacked = 1'b1;
    press();
    checks++;
    if ({status, hit_count, shots_left} !== {4'hE, 4'd1, 5'd2}) begin
      errors++;
      $display("FAIL reject_repeat got status=%h hits=%0d shots=%0d expected status=e hits=1 shots=2", status, hit_count, shots_left);
    end
    hh2 = 6'o05; cell_attacked = 1'b0;
    press();
    checks++;
    if ({status, shots_left} !== {4'hE, 5'd2}) begin
      errors++;
      $display("FAIL reject_col got status=%h shots=%0d expected status=e shots=2", status, shots_left);
    end
    set_mode(2'b00);
    checks++;
    if (status !== 4'h0) begin
      errors++;
      $display("FAIL err_clear_on_mode got %h expected 0", status);
    end
  endtask

  task automatic test_win();
    expect_strobe(K_CLR, 4'd0, 5'd3, 1'b0);
    press();
    set_mode(2'b01);
    expect_strobe(K_POS, 4'd0, 5'd3, 1'b0);
    press();
    set_mode(2'b10);
    hh2 = 6'o00; cell_occupied = 1'b0; cell_attacked = 1'b0;
    expect_strobe(K_AT, 4'd0, 5'd2, 1'b0);
    press();
    hh2 = 6'o64; cell_occupied = 1'b1;
    expect_strobe(K_AT, 4'd1, 5'd1, 1'b1);
    press();
    hh2 = 6'o40;
    expect_strobe(K_AT, 4'd2, 5'd0, 1'b1);
    press();
    checks++;
    if ({status, hit_count, shots_left, game_over} !== {4'h3, 4'd2, 5'd0, 1'b1}) begin
      errors++;
      $display("FAIL win got status=%h hits=%0d shots=%0d go=%b expected status=3 hits=2 shots=0 go=1", status, hit_count, shots_left, game_over);
    end
    hh2 = 6'o41;
    press();
    set_mode(2'b01);
    checks++;
    if ({status, hit_count, game_over} !== {4'h3, 4'd2, 1'b1}) begin
      errors++;
      $display("FAIL fim_hold got status=%h hits=%0d go=%b expected status=3 hits=2 go=1", status, hit_count, game_over);
    end
    set_mode(2'b00);
    checks++;
    if ({status, game_over} !== {4'h0, 1'b0}) begin
      errors++;
      $display("FAIL fim_exit got status=%h go=%b expected status=0 go=0", status, game_over);
    end
  endtask

  task automatic test_lose();
    expect_strobe(K_CLR, 4'd0, 5'd3, 1'b0);
    press();
    set_mode(2'b01);
    expect_strobe(K_POS, 4'd0, 5'd3, 1'b0);
    press();
    set_mode(2'b10);
    cell_occupied = 1'b0; cell_attacked = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      hh2 = 6'(i * 8);
      expect_strobe(K_AT, 4'd0, 5'(3 - i), 1'b0);
      press();
    end
    checks++;
    if ({status, shots_left, game_over} !== {4'h4, 5'd0, 1'b1}) begin
      errors++;
      $display("FAIL lose got status=%h shots=%0d go=%b expected status=4 shots=0 go=1", status, shots_left, game_over);
    end
    hh2 = 6'o50;
    press();
    checks++;
    if ({status, shots_left} !== {4'h4, 5'd0}) begin
      errors++;
      $display("FAIL no_underflow got status=%h shots=%0d expected status=4 shots=0", status, shots_left);
    end
    set_mode(2'b00);
  endtask

  task automatic test_clr_mid_game();
    int p0;
    expect_strobe(K_CLR, 4'd0, 5'd3, 1'b0);
    press();
    set_mode(2'b01);
    expect_strobe(K_POS, 4'd0, 5'd3, 1'b0);
    press();
    set_mode(2'b10);
    hh2 = 6'o11; cell_occupied = 1'b1; cell_attacked = 1'b0;
    expect_strobe(K_AT, 4'd1, 5'd2, 1'b1);
    press();
    button_confirmation = 1'b0;
    wait_cyc(4);
    clr = 1'b0;
    wait_cyc(2);
    checks++;
    if ({confirm_pulse, store_pos, store_at, clr_mats, hit_flag, hit_count, shots_left, status, game_over} !==
        {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 5'd3, 4'h0, 1'b0}) begin
      errors++;
      $display("FAIL clr_mid_game got hits=%0d shots=%0d flag=%b status=%h expected hits=0 shots=3 flag=0 status=0", hit_count, shots_left, hit_flag, status);
    end
    p0 = n_pulses;
    clr = 1'b1;
    wait_cyc(20);
    button_confirmation = 1'b1;
    wait_cyc(20);
    checks++;
    if (n_pulses != p0) begin
      errors++;
      $display("FAIL no_pulse_after_clr got %0d expected 0", n_pulses - p0);
    end
    press();
    checks++;
    if ({status, hit_count, shots_left} !== {4'hE, 4'd0, 5'd3}) begin
      errors++;
      $display("FAIL pos_valid_cleared got status=%h hits=%0d shots=%0d expected status=e hits=0 shots=3", status, hit_count, shots_left);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_bounce();
    test_position_attack();
    test_reject();
    test_win();
    test_lose();
    test_clr_mid_game();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
